// File: rtl/me_search_ctrl.sv
// ---------------------------------------------------------------------------
// me_search_ctrl
// Sequencing controller for the full-search block-matching engine.
// After an init pulse it streams 320 input words into the current-block (64)
// and search-window (256) buffers. It then steps the SAD datapath through all
// 16x16 candidate displacements, keeps the minimum-SAD motion vector, and
// shifts the 20-bit result out on serial20 (start bit, then MSB first).
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   init              one-cycle start / restart pulse (aborts a running job)
//   input_raw         input word, one per cycle during load
//   wr_data           registered copy of input_raw for the buffers
//   cur_we/cur_addr   current-block buffer write port
//   win_we/win_addr   search-window buffer write port
//   cand_start        one-cycle pulse launching a SAD evaluation
//   cand_x/cand_y     signed candidate displacement, -8..+7
//   sad_valid/sad     datapath result strobe and value
//   busy              high whenever the controller is not idle
//   done              one-cycle pulse after the final serial bit
//   serial20          serial result line, idles low
//
// Build option
//   ME_SEARCH_CTRL_EARLY_TERM_EN : a zero SAD ends the search immediately.
// ---------------------------------------------------------------------------
module me_search_ctrl #(
   parameter int unsigned WORD_WIDETH = 8,
   parameter int unsigned CUR_WORDS   = 64,
   parameter int unsigned WIN_WORDS   = 256,
   parameter int unsigned SAD_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     init,
   input  logic [WORD_WIDETH*4-1:0] input_raw,
   output logic [31:0]              wr_data,
   output logic                     cur_we,
   output logic [5:0]               cur_addr,
   output logic                     win_we,
   output logic [7:0]               win_addr,
   output logic                     cand_start,
   output logic [4:0]               cand_x,
   output logic [4:0]               cand_y,
   input  logic                     sad_valid,
   input  logic [SAD_W-1:0]         sad,
   output logic                     busy,
   output logic                     done,
   output logic                     serial20
);

   localparam int unsigned TOTAL_WORDS = CUR_WORDS + WIN_WORDS;
   localparam int unsigned CNT_W       = $clog2(TOTAL_WORDS + 1);
   localparam int unsigned RES_W       = 20;
   localparam int unsigned BIT_CNT_W   = 5;
   localparam int unsigned SAT_MAX     = 1023;
   localparam logic [4:0]  C_MIN       = 5'b11000;   // -8
   localparam logic [4:0]  C_MAX       = 5'b00111;   // +7

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_CUR,
      S_LOAD_WIN,
      S_ISSUE,
      S_WAIT,
      S_SER
   } state_t;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_word_cnt;
   logic [31:0]            r_wr_data;
   logic                   r_cur_we;
   logic [5:0]             r_cur_addr;
   logic                   r_win_we;
   logic [7:0]             r_win_addr;
   logic                   r_cand_start;
   logic [4:0]             r_cand_x;
   logic [4:0]             r_cand_y;
   logic                   r_first;
   logic [SAD_W-1:0]       r_min_sad;
   logic [4:0]             r_best_x;
   logic [4:0]             r_best_y;
   logic [RES_W-1:0]       r_shift;
   logic [BIT_CNT_W-1:0]   r_bit_cnt;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_serial;

   logic                   w_take;
   logic                   w_early;
   logic                   w_last_x;
   logic                   w_last_cand;
   logic [4:0]             w_best_x;
   logic [4:0]             w_best_y;
   logic [SAD_W-1:0]       w_best_sad;
   logic [9:0]             w_sad_sat;
   logic [RES_W-1:0]       w_frame;

   // Strict less-than keeps the earliest raster-order candidate on ties.
   assign w_take      = r_first | (sad < r_min_sad);
   assign w_last_x    = (r_cand_x == C_MAX);
   assign w_last_cand = w_last_x & (r_cand_y == C_MAX);

`ifdef ME_SEARCH_CTRL_EARLY_TERM_EN
   assign w_early = (sad == '0);
`else
   assign w_early = 1'b0;
`endif

   // Best-so-far including the result arriving this cycle, so the final
   // candidate is reflected in the frame loaded on entry to serialization.
   assign w_best_x   = w_take ? r_cand_x : r_best_x;
   assign w_best_y   = w_take ? r_cand_y : r_best_y;
   assign w_best_sad = w_take ? sad      : r_min_sad;
   assign w_sad_sat  = (w_best_sad > SAD_W'(SAT_MAX)) ? 10'(SAT_MAX) : 10'(w_best_sad);
   assign w_frame    = {w_best_x, w_best_y, w_sad_sat};

   // Controller FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_word_cnt   <= '0;
         r_wr_data    <= '0;
         r_cur_we     <= 1'b0;
         r_cur_addr   <= '0;
         r_win_we     <= 1'b0;
         r_win_addr   <= '0;
         r_cand_start <= 1'b0;
         r_cand_x     <= '0;
         r_cand_y     <= '0;
         r_first      <= 1'b1;
         r_min_sad    <= '0;
         r_best_x     <= '0;
         r_best_y     <= '0;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_serial     <= 1'b0;
      end else begin
         r_cur_we     <= 1'b0;
         r_win_we     <= 1'b0;
         r_cand_start <= 1'b0;
         r_done       <= 1'b0;

         if (init) begin
            // Start or abort: restart the load, forget the previous search.
            r_state    <= S_LOAD_CUR;
            r_busy     <= 1'b1;
            r_word_cnt <= '0;
            r_first    <= 1'b1;
            r_min_sad  <= '0;
            r_best_x   <= '0;
            r_best_y   <= '0;
            r_cand_x   <= '0;
            r_cand_y   <= '0;
            r_bit_cnt  <= '0;
            r_serial   <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_busy <= 1'b0;
               end

               S_LOAD_CUR: begin
                  r_wr_data  <= 32'(input_raw);
                  r_cur_we   <= 1'b1;
                  r_cur_addr <= 6'(r_word_cnt);
                  r_word_cnt <= r_word_cnt + CNT_W'(1);
                  if (r_word_cnt == CNT_W'(CUR_WORDS - 1)) begin
                     r_state <= S_LOAD_WIN;
                  end
               end

               S_LOAD_WIN: begin
                  r_wr_data  <= 32'(input_raw);
                  r_win_we   <= 1'b1;
                  r_win_addr <= 8'(r_word_cnt - CNT_W'(CUR_WORDS));
                  r_word_cnt <= r_word_cnt + CNT_W'(1);
                  if (r_word_cnt == CNT_W'(TOTAL_WORDS - 1)) begin
                     r_state      <= S_ISSUE;
                     r_cand_start <= 1'b1;
                     r_cand_x     <= C_MIN;
                     r_cand_y     <= C_MIN;
                  end
               end

               // cand_start is high for exactly the cycle spent here.
               S_ISSUE: begin
                  r_state <= S_WAIT;
               end

               S_WAIT: begin
                  if (sad_valid) begin
                     if (w_take) begin
                        r_first   <= 1'b0;
                        r_min_sad <= sad;
                        r_best_x  <= r_cand_x;
                        r_best_y  <= r_cand_y;
                     end
                     if (w_last_cand || w_early) begin
                        r_state   <= S_SER;
                        r_serial  <= 1'b1;
                        r_shift   <= w_frame;
                        r_bit_cnt <= '0;
                     end else begin
                        r_state      <= S_ISSUE;
                        r_cand_start <= 1'b1;
                        if (w_last_x) begin
                           r_cand_x <= C_MIN;
                           r_cand_y <= r_cand_y + 5'd1;
                        end else begin
                           r_cand_x <= r_cand_x + 5'd1;
                        end
                     end
                  end
               end

               // Start bit already driven; shift 20 data bits, then finish.
               S_SER: begin
                  if (r_bit_cnt == BIT_CNT_W'(RES_W)) begin
                     r_serial <= 1'b0;
                     r_done   <= 1'b1;
                     r_busy   <= 1'b0;
                     r_state  <= S_IDLE;
                  end else begin
                     r_serial  <= r_shift[RES_W-1];
                     r_shift   <= {r_shift[RES_W-2:0], 1'b0};
                     r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                  end
               end

               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign wr_data    = r_wr_data;
   assign cur_we     = r_cur_we;
   assign cur_addr   = r_cur_addr;
   assign win_we     = r_win_we;
   assign win_addr   = r_win_addr;
   assign cand_start = r_cand_start;
   assign cand_x     = r_cand_x;
   assign cand_y     = r_cand_y;
   assign busy       = r_busy;
   assign done       = r_done;
   assign serial20   = r_serial;

endmodule

// File: tb/tb_me_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_me_search_ctrl
// Directed + randomized bench for me_search_ctrl. The bench plays the SAD
// datapath itself (fixed latency per job) from a 16x16 SAD map, and derives
// the expected winner, candidate count and serial frame from that map by a
// plain raster scan.
// ---------------------------------------------------------------------------
module tb_me_search_ctrl;

   localparam int unsigned SW    = 16;
   localparam int unsigned RES_W = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          init;
   logic [31:0]   input_raw;
   logic [31:0]   wr_data;
   logic          cur_we;
   logic [5:0]    cur_addr;
   logic          win_we;
   logic [7:0]    win_addr;
   logic          cand_start;
   logic [4:0]    cand_x;
   logic [4:0]    cand_y;
   logic          sad_valid;
   logic [SW-1:0] sad;
   logic          busy;
   logic          done;
   logic          serial20;

   int            total = 0;
   int            bad = 0;
   int            done_cnt = 0;
   int unsigned   sad_map [16][16];
   logic [31:0]   words [320];
   bit            early_en;

   me_search_ctrl #(
      .WORD_WIDETH (8),
      .CUR_WORDS   (64),
      .WIN_WORDS   (256),
      .SAD_W       (SW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .init       (init),
      .input_raw  (input_raw),
      .wr_data    (wr_data),
      .cur_we     (cur_we),
      .cur_addr   (cur_addr),
      .win_we     (win_we),
      .win_addr   (win_addr),
      .cand_start (cand_start),
      .cand_x     (cand_x),
      .cand_y     (cand_y),
      .sad_valid  (sad_valid),
      .sad        (sad),
      .busy       (busy),
      .done       (done),
      .serial20   (serial20)
   );

   always #5 clk = ~clk;

   // Count done pulses as seen at each rising edge.
   always @(posedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int unsigned v);
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            sad_map[y][x] = v;
   endtask

   task automatic fill_random(input int unsigned lo, input int unsigned hi, input int unsigned step);
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            sad_map[y][x] = $urandom_range(hi, lo) * step;
   endtask

   // init pulse, then 320 random words; sad_valid noise must be ignored.
   task automatic load_job();
      for (int k = 0; k < 320; k++) words[k] = $urandom;
      init = 1'b1;
      tick();
      init = 1'b0;
      check("busy_after_init", 32'(busy), 32'(1));
      check("no_start_after_init", 32'(cand_start), 32'(0));
      for (int k = 0; k < 320; k++) begin
         input_raw = words[k];
         sad_valid = 1'($urandom);
         sad       = '0;
         tick();
         if (k < 64) begin
            check("cur_we", 32'(cur_we), 32'(1));
            check("cur_addr", 32'(cur_addr), 32'(k));
            check("win_we_low", 32'(win_we), 32'(0));
         end else begin
            check("win_we", 32'(win_we), 32'(1));
            check("win_addr", 32'(win_addr), 32'(k - 64));
            check("cur_we_low", 32'(cur_we), 32'(0));
         end
         check("wr_data", wr_data, words[k]);
         check("first_cand_start", 32'(cand_start), 32'(k == 319));
      end
      sad_valid = 1'b0;
   endtask

   // Play the datapath and read the serial frame. abort_at >= 0 stops before
   // answering that candidate; rst_bit >= 0 asserts rst during that data bit.
   task automatic search_job(input int lat, input int abort_at, input int rst_bit,
                             output int issued, output logic [19:0] rx);
      int           exp_n;
      int           w;
      int unsigned  bs;
      int unsigned  s;
      bit           first;
      logic [4:0]   bx, by, ex, ey;
      logic [9:0]   sat;
      logic [19:0]  frame;

      first = 1'b1; exp_n = 0; bs = 0; bx = '0; by = '0;
      issued = 0; rx = '0;
      for (int n = 0; n < 256; n++) begin
         s = sad_map[n/16][n%16];
         exp_n++;
         if (first || s < bs) begin
            first = 1'b0;
            bs = s;
            bx = 5'(n%16 - 8);
            by = 5'(n/16 - 8);
         end
         if (early_en && s == 0) break;
      end
      sat   = (bs > 1023) ? 10'd1023 : 10'(bs);
      frame = {bx, by, sat};

      for (int n = 0; n < exp_n; n++) begin
         w = 0;
         while (cand_start !== 1'b1 && w < 20) begin
            tick();
            w++;
         end
         check("cand_start_delay", 32'(w), 32'(0));
         if (cand_start !== 1'b1) return;
         issued++;
         ex = 5'(n%16 - 8);
         ey = 5'(n/16 - 8);
         check("cand_x", 32'(cand_x), 32'(ex));
         check("cand_y", 32'(cand_y), 32'(ey));
         for (int i = 0; i < lat; i++) begin
            tick();
            if (i == 0) check("cand_start_width", 32'(cand_start), 32'(0));
         end
         if (n == abort_at) return;
         check("cand_hold", 32'({cand_y, cand_x}), 32'({ey, ex}));
         sad_valid = 1'b1;
         sad       = SW'(sad_map[n/16][n%16]);
         tick();
         sad_valid = 1'b0;
         sad       = SW'($urandom);
      end

      check("start_bit", 32'(serial20), 32'(1));
      check("no_extra_cand", 32'(cand_start), 32'(0));
      for (int b = RES_W - 1; b >= 0; b--) begin
         tick();
         rx = {rx[18:0], serial20};
         if (b == rst_bit) begin
            #3 rst = 1'b1;
            #1;
            check("rst_serial20", 32'(serial20), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_done", 32'(done), 32'(0));
            check("rst_cand_x", 32'(cand_x), 32'(0));
            tick();
            rst = 1'b0;
            return;
         end
      end
      check("frame", 32'(rx), 32'(frame));
      check("busy_in_ser", 32'(busy), 32'(1));
      check("done_early", 32'(done), 32'(0));
      tick();
      check("done_pulse", 32'(done), 32'(1));
      check("serial_idle", 32'(serial20), 32'(0));
      check("busy_end", 32'(busy), 32'(0));
      tick();
      check("done_width", 32'(done), 32'(0));
   endtask

   initial begin
      int          issued;
      int          dc;
      int          exp_issued;
      logic [19:0] rx;

      early_en = 1'b0;
`ifdef ME_SEARCH_CTRL_EARLY_TERM_EN
      early_en = 1'b1;
`endif
      rst = 1'b1; init = 1'b0; input_raw = '0; sad_valid = 1'b0; sad = '0;
      tick();
      tick();
      check("rst_busy0", 32'(busy), 32'(0));
      check("rst_done0", 32'(done), 32'(0));
      check("rst_serial0", 32'(serial20), 32'(0));
      check("rst_cand_start0", 32'(cand_start), 32'(0));
      check("rst_cand_x0", 32'(cand_x), 32'(0));
      check("rst_cand_y0", 32'(cand_y), 32'(0));
      check("rst_cur_we0", 32'(cur_we), 32'(0));
      check("rst_win_we0", 32'(win_we), 32'(0));
      check("rst_wr_data0", wr_data, 32'(0));
      rst = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'(0));

      // Single minimum 37 at (+3,-2), latency 4.
      fill(500);
      sad_map[6][11] = 37;
      load_job();
      search_job(4, -1, -1, issued, rx);
      check("tp1_issued", 32'(issued), 32'(256));
      check("tp1_frame", 32'(rx), 32'({5'b00011, 5'b11110, 10'b0000100101}));
      check("tp1_done_cnt", 32'(done_cnt), 32'(1));

      // All equal: first candidate wins, SAD saturates.
      fill(2000);
      load_job();
      search_job(2, -1, -1, issued, rx);
      check("tp2_frame", 32'(rx), 32'({5'b11000, 5'b11000, 10'h3FF}));

      // Zero SAD at (-8,-7).
      fill_random(1, 30, 100);
      sad_map[1][0] = 0;
      exp_issued = early_en ? 17 : 256;
      load_job();
      search_job(3, -1, -1, issued, rx);
      check("tp3_issued", 32'(issued), 32'(exp_issued));
      check("tp3_frame", 32'(rx), 32'({5'b11000, 5'b11001, 10'd0}));

      // Random map with many ties, random latency.
      fill_random(5, 12, 100);
      load_job();
      search_job(int'($urandom_range(5, 1)), -1, -1, issued, rx);

      // Abort during WAIT, then a complete replacement job.
      fill_random(1, 40, 37);
      dc = done_cnt;
      load_job();
      search_job(3, 5, -1, issued, rx);
      load_job();
      fill_random(1, 40, 37);
      search_job(2, -1, -1, issued, rx);
      check("abort_done_cnt", 32'(done_cnt), 32'(dc + 1));

      // Reset in the middle of the serial frame.
      fill_random(1, 20, 60);
      dc = done_cnt;
      load_job();
      search_job(1, -1, 12, issued, rx);
      tick();
      tick();
      check("post_rst_busy", 32'(busy), 32'(0));
      check("post_rst_cur_we", 32'(cur_we), 32'(0));
      check("post_rst_serial", 32'(serial20), 32'(0));
      check("post_rst_done_cnt", 32'(done_cnt), 32'(dc));

      // Recovery after reset.
      fill_random(2, 9, 250);
      load_job();
      search_job(int'($urandom_range(4, 1)), -1, -1, issued, rx);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
